psum_drain: RTL and testbench
=============================

# psum_drain

Drain and requantization stage that sits downstream of the partial-sum accumulator in the RepVGG conv datapath. On a `start` pulse it captures one accumulated 288-bit vector (nine signed 32-bit lanes) together with per-lane biases. It then walks the lanes one per cycle: bias add, rounding arithmetic shift, optional ReLU, and int8 saturation. The packed int8 vector is presented on a valid/ready output port, and the block tells the accumulator side when its contents have been taken.

## Interface
- `DW`, default 288: input bus width; must be a multiple of 32.
- `LANES`, default `DW/32` (9): number of 32-bit lanes.
- `OW`, default 8: output bits per lane.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  capture request; sampled only in IDLE.
- `din`  input  DW  accumulated partial sums; lane i is `din[i*32+:32]`, signed.
- `bias`  input  DW  per-lane signed 32-bit bias, same lane layout.
- `shift`  input  5  right-shift amount, 0..31; captured with `din`.
- `acc_clr`  output  1  one-cycle pulse telling the accumulator its value was captured and it may clear.
- `busy`  output  1  high from capture until output transfer.
- `out_valid`  output  1  packed result valid.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  LANES*OW  lane i is `out_data[i*OW+:OW]`, signed int8.
- `done`  output  1  one-cycle pulse after output transfer.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: lane counter 0..LANES-1.
  - OUT: holds the packed result until transfer.
- IDLE → CALC when `start`=1:
  - Register `din`, `bias` and `shift`.
  - Lane counter ← 0, `busy` ← 1.
  - Pulse `acc_clr` in the following cycle.
- `start` while not in IDLE is ignored; no queuing.
- CALC, one lane per cycle, lane k:
  - s = sext34(psum_k) + sext34(bias_k) + (shift ≠ 0 ? 2^(shift-1) : 0).
  - r = s >>> shift (arithmetic shift).
  - Saturate r to [-128, 127].
  - Write the result to output buffer lane k.
- CALC → OUT after lane LANES-1 is written.
- OUT:
  - `out_valid` = 1 and `out_data` stays stable until `out_valid && out_ready` at a rising edge.
  - On that edge: go to IDLE, `busy` ← 0, `out_valid` ← 0, `done` pulses for the next cycle.
- `out_ready` is ignored outside OUT.
- The output buffer keeps its last value after transfer; it is not cleared.

## Timing
- Reset values:
  - State IDLE, lane counter 0.
  - Captured registers 0, `out_data` 0.
  - `busy`, `out_valid`, `acc_clr`, `done` all 0.
- `start` sampled at edge E0. In the cycle after E0: `busy` = 1 and `acc_clr` = 1 (for exactly that one cycle).
- Lane k is written at edge E(k+1). `out_valid` rises after edge E(LANES), so latency from `start` to `out_valid` is LANES+1 cycles (10 by default).
- When `out_ready` is already high, the transfer happens on the first valid cycle. Minimum start-to-start spacing is LANES+2 cycles.
- A new `start` asserted during the `done` cycle is accepted.
- Asserting `rst_n` low mid-operation abandons the current vector immediately: no `done`, no `out_valid`, outputs return to reset values.

## Configuration
- `PSUM_DRAIN_RELU_EN`:
  - Defined: after the shift, negative r is forced to 0 before saturation, so the output range is [0, 127].
  - Undefined: signed saturation only, output range [-128, 127].
  - Neither the port list nor the latency changes.

## Structure
- Shared package `psum_pkg` holds:
  - Constants `LANE_W` = 32, `OUT_W` = 8, `SAT_MAX` = 127, `SAT_MIN` = -128.
  - State encoding IDLE / CALC / OUT.
- One combinational sub-module `psum_requant` (one lane):
  - Inputs: psum, bias, shift.
  - Output: int8.
  - Contains the rounding, shift, ReLU (macro-gated) and saturation.
- `psum_drain` holds the FSM, capture registers, lane counter, output buffer and handshake logic.

## Test plan
- Basic, `shift`=0: all psum = 5, all bias = 3, `out_ready`=1 → `out_valid` 10 cycles after `start`, every lane = 8, `done` one cycle after transfer, `acc_clr` exactly once.
- Rounding, `shift`=4:
  - psum = 40, bias = 0 → 3, since (40+8)>>>4 = 3.
  - psum = -40 → -2, since (-40+8)>>>4 = -2.
- Saturation:
  - psum = 0x7FFFFFFF, bias = 0x7FFFFFFF, `shift`=0 → 127.
  - psum = 0x80000000, bias = 0x80000000 → -128, or 0 with `PSUM_DRAIN_RELU_EN`.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles → `out_valid` stays 1, `out_data` stable, extra `start` pulses ignored.
  - Release → transfer, then `done`.
- Reset mid-CALC: drop `rst_n` at lane 4 → all outputs 0 immediately, no `done`; next `start` runs normally.
- Back-to-back: `start` asserted in the `done` cycle with new data → accepted, second result correct.

Source files
------------

// File: rtl/psum_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
// Shared definitions for the partial-sum drain / requantization stage.
//   LANE_W  : width of one accumulated partial-sum / bias lane
//   OUT_W   : width of one requantized output lane (int8)
//   SAT_MAX : upper saturation bound of an output lane
//   SAT_MIN : lower saturation bound of an output lane
//   state_t : drain controller states
// ---------------------------------------------------------------------------
package psum_pkg;

  localparam int LANE_W  = 32;
  localparam int OUT_W   = 8;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/psum_requant.sv
// ---------------------------------------------------------------------------
// psum_requant
// Combinational requantization of one lane: bias add, round-half-up
// arithmetic right shift, optional ReLU, saturation to int8.
// Optional feature macro: PSUM_DRAIN_RELU_EN (negative results clamp to 0).
// Ports:
//   psum  in  LANE_W  signed accumulated partial sum
//   bias  in  LANE_W  signed bias
//   shift in  5       right-shift amount 0..31
//   q     out OUT_W   signed saturated result
// ---------------------------------------------------------------------------
module psum_requant
  import psum_pkg::*;
(
  input  logic [LANE_W-1:0] psum,
  input  logic [LANE_W-1:0] bias,
  input  logic [4:0]        shift,
  output logic [OUT_W-1:0]  q
);

  // Two guard bits: psum + bias + rounding constant cannot overflow 34 bits.
  localparam int SW = LANE_W + 2;

  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] clipped;

  always_comb begin
    rnd     = '0;
    if (shift != 5'd0) begin
      rnd = SW'(1) << (shift - 5'd1);
    end
    sum     = SW'($signed(psum)) + SW'($signed(bias)) + rnd;
    shifted = sum >>> shift;
`ifdef PSUM_DRAIN_RELU_EN
    clipped = shifted[SW-1] ? '0 : shifted;
`else
    clipped = shifted;
`endif
    if (clipped > SW'(SAT_MAX)) begin
      q = OUT_W'(SAT_MAX);
    end else if (clipped < SW'(SAT_MIN)) begin
      q = OUT_W'(SAT_MIN);
    end else begin
      q = clipped[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
// Captures one accumulated vector plus per-lane biases on start, requantizes
// one lane per cycle into an int8 output buffer and presents the packed
// result on a valid/ready port.
// Optional feature macro: PSUM_DRAIN_RELU_EN (see psum_requant).
// Ports:
//   clk, rst_n  clock (rising edge), async active-low reset
//   start       capture request, sampled only in IDLE
//   din, bias   DW-bit packed signed 32-bit lanes
//   shift       5-bit rounding right-shift, captured with din
//   acc_clr     one-cycle pulse after capture
//   busy        high from capture until output transfer
//   out_valid   packed result valid
//   out_ready   downstream accepts (ignored outside OUT)
//   out_data    LANES*OW packed signed int8 lanes
//   done        one-cycle pulse after output transfer
// ---------------------------------------------------------------------------
module psum_drain
  import psum_pkg::*;
#(
  parameter int DW    = 288,
  parameter int LANES = DW / 32,
  parameter int OW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DW-1:0]       din,
  input  logic [DW-1:0]       bias,
  input  logic [4:0]          shift,
  output logic                acc_clr,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*OW-1:0] out_data,
  output logic                done
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   lane_cnt;
  logic               last_lane;
  logic [DW-1:0]      din_q;
  logic [DW-1:0]      bias_q;
  logic [4:0]         shift_q;
  logic [LANES*OW-1:0] out_buf;
  logic [LANE_W-1:0]  psum_lane;
  logic [LANE_W-1:0]  bias_lane;
  logic [OUT_W-1:0]   lane_q;

  assign last_lane = (lane_cnt == CNT_W'(LANES - 1));
  assign out_data  = out_buf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_lane) begin
          state_next = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane mux feeding the single shared requantizer.
  always_comb begin
    psum_lane = din_q[lane_cnt*LANE_W +: LANE_W];
    bias_lane = bias_q[lane_cnt*LANE_W +: LANE_W];
  end

  psum_requant u_requant (
    .psum  (psum_lane),
    .bias  (bias_lane),
    .shift (shift_q),
    .q     (lane_q)
  );

  // Capture registers, lane counter, output buffer and handshake pulses.
  // The output buffer is deliberately not cleared after a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q    <= '0;
      bias_q   <= '0;
      shift_q  <= '0;
      lane_cnt <= '0;
      out_buf  <= '0;
      acc_clr  <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            din_q    <= din;
            bias_q   <= bias;
            shift_q  <= shift;
            lane_cnt <= '0;
            acc_clr  <= 1'b1;
          end
        end
        CALC: begin
          out_buf[lane_cnt*OW +: OW] <= OW'($signed(lane_q));
          lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// ---------------------------------------------------------------------------
// tb_psum_drain
// Directed self-checking bench for psum_drain. Expected lane values are
// hand-computed; PSUM_DRAIN_RELU_EN selects the ReLU variant of expectations.
// ---------------------------------------------------------------------------
module tb_psum_drain;

  localparam int DW    = 288;
  localparam int LANES = 9;
  localparam int OW    = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [DW-1:0]       din;
  logic [DW-1:0]       bias;
  logic [4:0]          shift;
  logic                acc_clr;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*OW-1:0] out_data;
  logic                done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int accClrCount = 0;
  int psumV [LANES];
  int biasV [LANES];
  int expV  [LANES];

  psum_drain #(.DW(DW), .LANES(LANES), .OW(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .bias      (bias),
    .shift     (shift),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Count acc_clr pulses away from the active edge.
  always @(negedge clk) begin
    if (acc_clr === 1'b1) accClrCount++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int relu(input int v);
`ifdef PSUM_DRAIN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] packPsum();
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = psumV[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] packBias();
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = biasV[i];
    return r;
  endfunction

  function automatic logic [LANES*OW-1:0] packExp();
    logic [LANES*OW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*OW +: OW] = 8'(expV[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [LANES*OW-1:0] obs,
                             input logic [LANES*OW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load the lane tables onto the inputs and pulse start across one edge.
  task automatic applyStimulus(input logic [4:0] sh);
    din   = packPsum();
    bias  = packBias();
    shift = sh;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for out_valid after applyStimulus; check latency and data.
  task automatic awaitResult(input string tag);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_latency"}, 72'(cyc), 72'd9);
    checkOutput({tag, "_data"}, out_data, packExp());
  endtask

  task automatic expectDone(input string tag);
    tick();
    checkOutput({tag, "_done"}, 72'(done), 72'd1);
    checkOutput({tag, "_valid_drop"}, 72'(out_valid), 72'd0);
    checkOutput({tag, "_busy_drop"}, 72'(busy), 72'd0);
  endtask

  initial begin
    int accBase;
    int sawActivity;

    rst_n = 1'b0; start = 1'b0; din = '0; bias = '0; shift = '0; out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", 72'(busy), 72'd0);
    checkOutput("reset_valid", 72'(out_valid), 72'd0);
    checkOutput("reset_accclr", 72'(acc_clr), 72'd0);
    checkOutput("reset_done", 72'(done), 72'd0);
    checkOutput("reset_data", out_data, 72'd0);
    rst_n = 1'b1;
    tick();

    // Basic: 5 + 3, shift 0 -> 8 in every lane.
    $display("[TB] basic");
    psumV = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
    biasV = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    expV  = '{8, 8, 8, 8, 8, 8, 8, 8, 8};
    out_ready = 1'b1;
    accBase = accClrCount;
    applyStimulus(5'd0);
    checkOutput("basic_busy", 72'(busy), 72'd1);
    checkOutput("basic_accclr", 72'(acc_clr), 72'd1);
    checkOutput("basic_valid_early", 72'(out_valid), 72'd0);
    awaitResult("basic");
    expectDone("basic");
    tick();
    checkOutput("basic_done_once", 72'(done), 72'd0);
    checkOutput("basic_accclr_count", 72'(accClrCount - accBase), 72'd1);

    // Rounding with shift 4.
    $display("[TB] rounding");
    psumV = '{40, -40, 100, -100, 0, 7, 8, -8, -9};
    biasV = '{0, 0, 20, -28, 0, 0, 0, 0, 0};
    expV  = '{3, relu(-2), 8, relu(-8), 0, 0, 1, 0, relu(-1)};
    applyStimulus(5'd4);
    awaitResult("round");
    expectDone("round");

    // Saturation with shift 0.
    $display("[TB] saturation");
    psumV = '{32'sh7FFFFFFF, 32'sh80000000, 127, 128, -128, -129, 32'sh7FFFFFFF, 1000, 100};
    biasV = '{32'sh7FFFFFFF, 32'sh80000000, 0, 0, 0, 0, 32'sh80000000, -1000, 27};
    expV  = '{127, relu(-128), 127, 127, relu(-128), relu(-128), relu(-1), 0, 127};
    tick();
    applyStimulus(5'd0);
    awaitResult("sat");
    expectDone("sat");

    // Backpressure: hold out_ready low, poke start, data must stay put.
    $display("[TB] backpressure");
    psumV = '{0, 10, 20, 30, 40, 50, 60, 70, 80};
    biasV = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    expV  = '{0, 6, 11, 17, 22, 28, 33, 39, 44};
    out_ready = 1'b0;
    tick();
    accBase = accClrCount;
    applyStimulus(5'd1);
    awaitResult("bp");
    din  = ~din;
    bias = ~bias;
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
      checkOutput("bp_hold_valid", 72'(out_valid), 72'd1);
      checkOutput("bp_hold_data", out_data, packExp());
    end
    start = 1'b0;
    checkOutput("bp_start_ignored", 72'(accClrCount - accBase), 72'd1);
    out_ready = 1'b1;
    expectDone("bp");
    tick();
    checkOutput("bp_buffer_kept", out_data, packExp());

    // Reset while lane 4 is being processed.
    $display("[TB] reset mid-calc");
    psumV = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
    biasV = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    expV  = '{8, 8, 8, 8, 8, 8, 8, 8, 8};
    applyStimulus(5'd0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 72'(busy), 72'd0);
    checkOutput("rst_valid", 72'(out_valid), 72'd0);
    checkOutput("rst_data", out_data, 72'd0);
    checkOutput("rst_accclr", 72'(acc_clr), 72'd0);
    checkOutput("rst_done", 72'(done), 72'd0);
    tick();
    rst_n = 1'b1;
    sawActivity = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) sawActivity = 1;
    end
    checkOutput("rst_no_activity", 72'(sawActivity), 72'd0);
    applyStimulus(5'd0);
    awaitResult("post_rst");
    expectDone("post_rst");

    // Back-to-back: second start lands in the done cycle.
    $display("[TB] back-to-back");
    psumV = '{40, -40, 100, -100, 0, 7, 8, -8, -9};
    biasV = '{0, 0, 20, -28, 0, 0, 0, 0, 0};
    expV  = '{3, relu(-2), 8, relu(-8), 0, 0, 1, 0, relu(-1)};
    applyStimulus(5'd4);
    awaitResult("b2b_first");
    tick();
    checkOutput("b2b_first_done", 72'(done), 72'd1);
    psumV = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh40000000, 0, 0, 0, 0, 0, 0};
    biasV = '{32'sh7FFFFFFF, 32'sh80000000, 0, 0, 0, 0, 0, 0, 0};
    expV  = '{2, relu(-2), 1, 0, 0, 0, 0, 0, 0};
    accBase = accClrCount;
    applyStimulus(5'd31);
    checkOutput("b2b_accepted_busy", 72'(busy), 72'd1);
    checkOutput("b2b_accepted_accclr", 72'(acc_clr), 72'd1);
    awaitResult("b2b_second");
    expectDone("b2b_second");
    tick();
    checkOutput("b2b_accclr_count", 72'(accClrCount - accBase), 72'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
